core_ma_lsu_store_gen: RTL

Store-side companion of the memory-access stage load path. It accepts one store request at a time from the MA stage (address, size, data) and drives the Avalon-MM master port `avl_m0` with word-aligned writes, correct byte enables and byte-shifted data. A store whose bytes cross a 32-bit word boundary is split into two consecutive word writes. Completion is reported back to the pipeline with a single-cycle done pulse.

---
 rtl/core_lsu_pkg.sv | 41 ++++
 rtl/core_ma_lsu_store_gen_if.sv | 32 +++
 rtl/core_lsu_store_lane.sv | 34 +++
 rtl/core_ma_lsu_store_gen.sv | 130 +++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// Shared LSU definitions: FSM states, store size codes, bus beat payload and
// the word-crossing helper used by both the load and store paths.
package core_lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 32;
    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_BE_W   = LSU_DATA_W / 8;

    localparam logic [2:0] LSU_LEN_B = 3'd1;
    localparam logic [2:0] LSU_LEN_H = 3'd2;
    localparam logic [2:0] LSU_LEN_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1,
        ST_WR1  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_BE_W-1:0]   be;
        logic [LSU_DATA_W-1:0] data;
    } lsu_beat_t;

    // Anything that is not a byte or half is treated as a full word.
    function automatic logic [2:0] lsu_len_decode(input logic [2:0] len);
        logic [2:0] len_d;
        case (len)
            LSU_LEN_B: len_d = LSU_LEN_B;
            LSU_LEN_H: len_d = LSU_LEN_H;
            default:   len_d = LSU_LEN_W;
        endcase
        return len_d;
    endfunction

    function automatic logic lsu_cross(input logic [1:0] off, input logic [2:0] len);
        return (4'(off) + 4'(lsu_len_decode(len))) > 4'd4;
    endfunction

endpackage

// File: rtl/core_ma_lsu_store_gen_if.sv
// MA-stage store request/completion signals plus the Avalon-MM write port.
// master: the store generator; slave: the pipeline and memory side.
interface core_ma_lsu_store_gen_if;
    import core_lsu_pkg::*;

    logic                  mem_write;
    logic                  mem_write_ready;
    logic [LSU_ADDR_W-1:0] mem_addr;
    logic [2:0]            mem_op_data_len;
    logic [LSU_DATA_W-1:0] mem_write_data;
    logic                  mem_write_done;
    logic                  mem_write_err;

    logic [LSU_ADDR_W-1:0] avl_m0_address;
    logic                  avl_m0_write;
    logic [LSU_BE_W-1:0]   avl_m0_byte_enable;
    logic [LSU_DATA_W-1:0] avl_m0_write_data;
    logic                  avl_m0_wait_request;

    modport master (
        input  mem_write, mem_addr, mem_op_data_len, mem_write_data, avl_m0_wait_request,
        output mem_write_ready, mem_write_done, mem_write_err,
        output avl_m0_address, avl_m0_write, avl_m0_byte_enable, avl_m0_write_data
    );

    modport slave (
        output mem_write, mem_addr, mem_op_data_len, mem_write_data, avl_m0_wait_request,
        input  mem_write_ready, mem_write_done, mem_write_err,
        input  avl_m0_address, avl_m0_write, avl_m0_byte_enable, avl_m0_write_data
    );

endinterface

// File: rtl/core_lsu_store_lane.sv
// Store lane generator: positions right-aligned store data and byte enables
// across an 8-byte window starting at the word holding the store address.
module core_lsu_store_lane
    import core_lsu_pkg::*;
(
    input  logic [1:0]              off,
    input  logic [2:0]              len,
    input  logic [LSU_DATA_W-1:0]   data,
    output logic [2*LSU_BE_W-1:0]   be8_c,
    output logic [2*LSU_DATA_W-1:0] d64_c,
    output logic                    cross_c
);

    logic [LSU_BE_W-1:0]   mask;
    logic [LSU_DATA_W-1:0] data_m;

    // Bytes beyond the store size are zeroed so unused lanes stay quiet.
    always_comb begin
        mask   = 4'b1111;
        data_m = '0;
        case (lsu_len_decode(len))
            LSU_LEN_B: mask = 4'b0001;
            LSU_LEN_H: mask = 4'b0011;
            default:   mask = 4'b1111;
        endcase
        for (int i = 0; i < int'(LSU_BE_W); i++) begin
            data_m[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
        end
        be8_c   = 8'(mask) << off;
        d64_c   = 64'(data_m) << {off, 3'b000};
        cross_c = lsu_cross(off, len);
    end

endmodule

// File: rtl/core_ma_lsu_store_gen.sv
// MA-stage store generator: turns one store request into one or two
// word-aligned Avalon-MM writes. Splitting of word-crossing stores is enabled
// by CORE_LSU_MISALIGN_STORE_EN; without it such stores complete with an error.
module core_ma_lsu_store_gen
    import core_lsu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rest,
    core_ma_lsu_store_gen_if.master bus
);

`ifdef CORE_LSU_MISALIGN_STORE_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e state_q, state_nxt;
    lsu_beat_t  beat_q, beat_nxt;
    lsu_beat_t  hi_q, hi_nxt;
    logic       write_q, write_nxt;
    logic       cross_q, cross_nxt;
    logic       done_q, done_nxt;
    logic       err_q, err_nxt;
    logic       ready_q, ready_nxt;

    logic [2*LSU_BE_W-1:0]   be8_c;
    logic [2*LSU_DATA_W-1:0] d64_c;
    logic                    cross_c;
    logic                    accept_c;
    logic                    beat_acc_c;
    logic [LSU_ADDR_W-1:0]   base_c;

    // Lanes are formed from the request as it is accepted so beat 0 can be
    // registered straight onto the bus in the following cycle.
    core_lsu_store_lane u_lane (
        .off     (bus.mem_addr[1:0]),
        .len     (bus.mem_op_data_len),
        .data    (bus.mem_write_data),
        .be8_c   (be8_c),
        .d64_c   (d64_c),
        .cross_c (cross_c)
    );

    assign accept_c   = bus.mem_write && ready_q;
    assign beat_acc_c = write_q && !bus.avl_m0_wait_request;
    assign base_c     = {bus.mem_addr[LSU_ADDR_W-1:2], 2'b00};

    // Next state and next register values. DONE also accepts a new request so
    // the done cycle can overlap the next accept.
    always_comb begin
        state_nxt = state_q;
        beat_nxt  = beat_q;
        hi_nxt    = hi_q;
        write_nxt = write_q;
        cross_nxt = cross_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept_c) begin
                    if (cross_c && !SPLIT_EN) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_WR0;
                        write_nxt = 1'b1;
                        cross_nxt = cross_c;
                        beat_nxt  = '{addr: base_c, be: be8_c[3:0], data: d64_c[31:0]};
                        hi_nxt    = '{addr: base_c + 32'd4, be: be8_c[7:4], data: d64_c[63:32]};
                    end
                end
            end
            ST_WR0: begin
                if (beat_acc_c) begin
                    if (cross_q) begin
                        state_nxt = ST_WR1;
                        beat_nxt  = hi_q;
                    end else begin
                        state_nxt = ST_DONE;
                        write_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_WR1: begin
                if (beat_acc_c) begin
                    state_nxt = ST_DONE;
                    write_nxt = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            hi_q    <= '0;
            write_q <= 1'b0;
            cross_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            beat_q  <= beat_nxt;
            hi_q    <= hi_nxt;
            write_q <= write_nxt;
            cross_q <= cross_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            ready_q <= ready_nxt;
        end
    end

    assign bus.mem_write_ready    = ready_q;
    assign bus.mem_write_done     = done_q;
    assign bus.mem_write_err      = err_q;
    assign bus.avl_m0_address     = beat_q.addr;
    assign bus.avl_m0_write       = write_q;
    assign bus.avl_m0_byte_enable = beat_q.be;
    assign bus.avl_m0_write_data  = beat_q.data;

endmodule
